dff_mon: RTL and testbench

- Synthesizable observer/checker for the 2:1 select-mux flip-flop (d0/d1/sel/rst in, q out); it is the receiving end of that block's pin interface.
- Samples the same pins the DUV sees and predicts q one cycle ahead. Compares the DUV's q against the prediction, then counts checks and errors and latches the first failure.
- Instantiated beside the DUV in top-level benches, and usable in FPGA builds as a self-check.

---
 rtl/dff_mon.sv | 130 +++++++++++++
 tb/tb_dff_mon.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dff_mon.sv
// Pin-level checker for the 2:1 select-mux flip-flop: predicts q one cycle ahead,
// compares against the observed q, counts checks/errors and latches the first failure.
module dff_mon #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clr_cnt,
    input  logic             mon_rst,
    input  logic             mon_sel,
    input  logic [WIDTH-1:0] mon_d0,
    input  logic [WIDTH-1:0] mon_d1,
    input  logic [WIDTH-1:0] mon_q,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_cap;
    logic             w_cmp;
    logic             w_mis;
    logic [WIDTH-1:0] w_pred;
    logic [WIDTH-1:0] r_exp;
    logic             r_err;
    logic             r_sticky;
    logic [CNT_W-1:0] r_check_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_first_vld;
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_got;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    // Only an unambiguous 1 on sel picks d1; X/Z falls through to d0.
    assign w_pred = mon_rst ? '0 : ((mon_sel === 1'b1) ? mon_d1 : mon_d0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // The enabling edge in IDLE captures the first prediction (entering PRIME);
    // the edge leaving PRIME is the first one that has a prediction to compare.
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_cmp       = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_cap       = 1'b1;
                    w_state_nxt = PRIME;
                end
            end
            PRIME, CHECK: begin
                if (enable) begin
                    w_cap       = 1'b1;
                    w_cmp       = 1'b1;
                    w_state_nxt = CHECK;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_mis = w_cmp && (mon_q !== r_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp       <= '0;
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
            r_check_cnt <= '0;
            r_err_cnt   <= '0;
            r_first_vld <= 1'b0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else begin
            if (w_cap) r_exp <= w_pred;
            r_err <= w_mis;
            // A clear on the same edge as a mismatch wins over counting/capture.
            if (clr_cnt) begin
                r_sticky    <= 1'b0;
                r_check_cnt <= '0;
                r_err_cnt   <= '0;
                r_first_vld <= 1'b0;
                r_first_exp <= '0;
                r_first_got <= '0;
            end else begin
                if (w_cmp) r_check_cnt <= sat_inc(r_check_cnt);
                if (w_mis) r_err_cnt <= sat_inc(r_err_cnt);
                if (w_mis && !r_first_vld) begin
                    r_first_vld <= 1'b1;
                    r_sticky    <= 1'b1;
                    r_first_exp <= r_exp;
                    r_first_got <= mon_q;
                end
            end
        end
    end

    assign err           = r_err;
    assign err_sticky    = r_sticky;
    assign check_cnt     = r_check_cnt;
    assign err_cnt       = r_err_cnt;
    assign first_err_vld = r_first_vld;
    assign first_err_exp = r_first_exp;
    assign first_err_got = r_first_got;

endmodule

// File: tb/tb_dff_mon.sv
// Scoreboard bench for dff_mon: predictions are queued as stimulus is driven and
// popped when the monitor performs the matching compare on the next edge.
module tb_dff_mon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        mon_rst = 1'b0;
    logic        mon_sel = 1'b0;
    logic [0:0]  mon_d0 = '0;
    logic [0:0]  mon_d1 = '0;
    logic [0:0]  mon_q = '0;

    logic        err, err_sticky, first_err_vld;
    logic [15:0] check_cnt, err_cnt;
    logic [0:0]  first_err_exp, first_err_got;

    logic        err4, err_sticky4, first_err_vld4;
    logic [3:0]  check_cnt4, err_cnt4;
    logic [0:0]  first_err_exp4, first_err_got4;

    int checks = 0;
    int failures = 0;

    logic        sb[$];
    logic        m_err, m_sticky, m_fvld, m_fexp, m_fgot;
    logic [15:0] m_chk, m_ecnt;
    logic [3:0]  m_chk4, m_ecnt4;
    logic [15:0] saved_chk;

    always #5 clk = ~clk;

    dff_mon #(.WIDTH(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_cnt(clr_cnt),
        .mon_rst(mon_rst), .mon_sel(mon_sel), .mon_d0(mon_d0), .mon_d1(mon_d1), .mon_q(mon_q),
        .err(err), .err_sticky(err_sticky), .check_cnt(check_cnt), .err_cnt(err_cnt),
        .first_err_vld(first_err_vld), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    dff_mon #(.WIDTH(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .clr_cnt(clr_cnt),
        .mon_rst(mon_rst), .mon_sel(mon_sel), .mon_d0(mon_d0), .mon_d1(mon_d1), .mon_q(mon_q),
        .err(err4), .err_sticky(err_sticky4), .check_cnt(check_cnt4), .err_cnt(err_cnt4),
        .first_err_vld(first_err_vld4), .first_err_exp(first_err_exp4), .first_err_got(first_err_got4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_sticky = 1'b0; m_fvld = 1'b0; m_fexp = 1'b0; m_fgot = 1'b0;
        m_chk = '0; m_ecnt = '0; m_chk4 = '0; m_ecnt4 = '0;
    endtask

    task automatic check_all();
        chk("err", err, m_err);
        chk("err_sticky", err_sticky, m_sticky);
        chk("check_cnt", check_cnt, m_chk);
        chk("err_cnt", err_cnt, m_ecnt);
        chk("first_err_vld", first_err_vld, m_fvld);
        chk("first_err_exp", first_err_exp, m_fexp);
        chk("first_err_got", first_err_got, m_fgot);
        chk("err_w4", err4, m_err);
        chk("check_cnt_w4", check_cnt4, m_chk4);
        chk("err_cnt_w4", err_cnt4, m_ecnt4);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; clr_cnt = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        sb.delete();
        m_err = 1'b0;
        model_clear();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // fault: 0 = correct DUV q, 1 = inverted q, 2 = X on q
    task automatic step(input logic en, input logic clr, input logic mr, input logic sel,
                        input logic d0, input logic d1, input int fault);
        logic qd, e, cmp, mis;
        @(negedge clk);
        qd = (sb.size() > 0) ? sb[0] : 1'b0;
        if (fault == 1) qd = ~qd;
        if (fault == 2) qd = 1'bx;
        enable = en; clr_cnt = clr; mon_rst = mr; mon_sel = sel;
        mon_d0 = d0; mon_d1 = d1; mon_q = qd;
        cmp = en && (sb.size() > 0);
        mis = 1'b0;
        if (cmp) begin
            e = sb.pop_front();
            mis = (qd !== e);
        end
        if (!en) sb.delete();
        else sb.push_back(mr ? 1'b0 : ((sel === 1'b1) ? d1 : d0));
        m_err = mis;
        if (clr) begin
            model_clear();
        end else begin
            if (cmp) begin
                if (m_chk != 16'hFFFF) m_chk++;
                if (m_chk4 != 4'hF) m_chk4++;
            end
            if (mis) begin
                if (m_ecnt != 16'hFFFF) m_ecnt++;
                if (m_ecnt4 != 4'hF) m_ecnt4++;
                if (!m_fvld) begin
                    m_fvld = 1'b1; m_sticky = 1'b1; m_fexp = e; m_fgot = qd;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        m_err = 1'b0;
        model_clear();
        do_reset(2);

        // Correct DUV over 10 enabled edges, including mon_rst
        repeat (2) step(1, 0, 1, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 1, 0, 0);
        repeat (2) step(1, 0, 0, 1, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 1, 0, 1, 0);
        chk("nine_checks", check_cnt, 16'd9);
        chk("no_errors", err_cnt, 16'd0);

        // exp=1 (from d1=1) observed as 0
        step(1, 0, 0, 0, 0, 0, 1);
        chk("mis1_err", err, 1'b1);
        chk("mis1_fexp", first_err_exp, 1'b1);
        chk("mis1_fgot", first_err_got, 1'b0);
        step(1, 0, 0, 0, 0, 0, 0);
        // exp=0 observed as 1; capture must not move
        step(1, 0, 0, 0, 0, 0, 1);
        chk("mis2_cnt", err_cnt, 16'd2);
        chk("mis2_fexp", first_err_exp, 1'b1);
        chk("mis2_fgot", first_err_got, 1'b0);

        // X on q while exp=0
        step(1, 0, 0, 0, 0, 0, 2);

        // Persistent mismatch saturates the narrow counters
        for (int i = 0; i < 20; i++) step(1, 0, 0, i[0], 1, 0, 1);
        chk("sat_chk4", check_cnt4, 4'hF);
        chk("sat_err4", err_cnt4, 4'hF);

        // Clear coincident with a mismatch
        step(1, 1, 0, 0, 1, 1, 1);
        chk("clr_err_pulse", err, 1'b1);
        chk("clr_err_cnt", err_cnt, 16'd0);
        chk("clr_fvld", first_err_vld, 1'b0);

        // Enable gap: idle edges and the first re-enabled edge do not compare
        step(1, 0, 0, 1, 0, 1, 0);
        saved_chk = check_cnt;
        repeat (3) step(0, 0, 0, 0, 1, 0, 0);
        chk("idle_hold", check_cnt, saved_chk);
        step(1, 0, 0, 0, 1, 0, 0);
        chk("reen_first", check_cnt, saved_chk);
        step(1, 0, 0, 1, 1, 0, 0);
        chk("reen_second", check_cnt, saved_chk + 16'd1);

        // Reset mid-stream, then re-prime
        do_reset(1);
        step(1, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("post_rst_cnt", check_cnt, 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
